// File: rtl/mem_line_bridge.sv
// ---------------------------------------------------------------------------
// mem_line_bridge
//
// Converts one cache-line request (read or write) into a command plus a burst
// of BEAT_BITS-wide beats on a simple external memory port, then returns a
// single-cycle completion pulse. Only one request is in flight at a time.
//
// Ports
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   mem_req_*            line request; valid is sampled only in IDLE
//   mem_rsp_valid        one-cycle completion pulse
//   mem_rsp_load_data    last read line (beats land here as they arrive)
//   ext_cmd_*            command handshake: line-aligned addr, write flag, tag
//   ext_wdata_*          write beat handshake, last on the final beat
//   ext_rdata_*          read beats, always accepted
//   ext_wack_valid       write burst complete
//   proto_err            sticky: read beat outside RDATA or wack outside WACK
//
// Optional build macro MEM_LINE_BRIDGE_STATS_EN adds 64-bit counters
//   bridge_reads, bridge_writes, bridge_busy_cycles.
// ---------------------------------------------------------------------------
module mem_line_bridge #(
  parameter int ADDR_WIDTH  = 32,
  parameter int CL_LEN_BITS = 128,
  parameter int BEAT_BITS   = 32,
  parameter int TAG_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [CL_LEN_BITS-1:0] mem_req_store_data,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  input  logic [3:0]             mem_req_opcode,
  output logic                   mem_rsp_valid,
  output logic [CL_LEN_BITS-1:0] mem_rsp_load_data,
  output logic                   ext_cmd_valid,
  input  logic                   ext_cmd_ready,
  output logic [ADDR_WIDTH-1:0]  ext_cmd_addr,
  output logic                   ext_cmd_write,
  output logic [TAG_WIDTH-1:0]   ext_cmd_tag,
  output logic                   ext_wdata_valid,
  input  logic                   ext_wdata_ready,
  output logic [BEAT_BITS-1:0]   ext_wdata,
  output logic                   ext_wdata_last,
  input  logic                   ext_rdata_valid,
  input  logic [BEAT_BITS-1:0]   ext_rdata,
  input  logic                   ext_wack_valid,
  output logic                   proto_err
`ifdef MEM_LINE_BRIDGE_STATS_EN
  ,
  output logic [63:0]            bridge_reads,
  output logic [63:0]            bridge_writes,
  output logic [63:0]            bridge_busy_cycles
`endif
);

  localparam int NBEATS   = CL_LEN_BITS / BEAT_BITS;
  localparam int CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_BITS = $clog2(CL_LEN_BITS / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  // Clears the byte-within-line bits so the external address is line aligned.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   write_q;
  logic [CL_LEN_BITS-1:0] store_q;
  logic [CL_LEN_BITS-1:0] load_q;
  logic                   err_q;
  logic                   capture;
  logic                   load_we;
  logic                   err_set;

  // Store line viewed as an array of beats for the write-beat mux.
  logic [BEAT_BITS-1:0] store_beats [NBEATS];

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beats
    assign store_beats[gi] = store_q[gi*BEAT_BITS +: BEAT_BITS];
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    capture         = 1'b0;
    load_we         = 1'b0;
    ext_cmd_valid   = 1'b0;
    ext_wdata_valid = 1'b0;
    ext_wdata_last  = 1'b0;
    mem_rsp_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_req_valid) begin
          capture = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        ext_cmd_valid = 1'b1;
        if (ext_cmd_ready) begin
          // Counter cleared explicitly on burst entry, never left to wrap.
          beat_d  = '0;
          state_d = write_q ? S_WDATA : S_RDATA;
        end
      end
      S_WDATA: begin
        ext_wdata_valid = 1'b1;
        ext_wdata_last  = (beat_q == LAST_BEAT);
        if (ext_wdata_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_WACK;
          end
        end
      end
      S_WACK: begin
        if (ext_wack_valid) begin
          state_d = S_RESP;
        end
      end
      S_RDATA: begin
        if (ext_rdata_valid) begin
          load_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        // Requester still holds mem_req_valid here; it is deliberately ignored.
        mem_rsp_valid = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err_set = (ext_rdata_valid && (state_q != S_RDATA)) ||
                   (ext_wack_valid  && (state_q != S_WACK));

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      write_q <= 1'b0;
      store_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (capture) begin
        addr_q  <= mem_req_addr & LINE_MASK;
        tag_q   <= mem_req_tag;
        write_q <= (mem_req_opcode == 4'd7);
        store_q <= mem_req_store_data;
      end
      // Beats overwrite the previous line in place, so the old line stays
      // visible until the first beat of the next read.
      for (int i = 0; i < NBEATS; i++) begin
        if (load_we && (beat_q == CNT_W'(i))) begin
          load_q[i*BEAT_BITS +: BEAT_BITS] <= ext_rdata;
        end
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ext_cmd_addr      = addr_q;
  assign ext_cmd_write     = write_q;
  assign ext_cmd_tag       = tag_q;
  assign ext_wdata         = store_beats[beat_q];
  assign mem_rsp_load_data = load_q;
  assign proto_err         = err_q;

`ifdef MEM_LINE_BRIDGE_STATS_EN
  logic [63:0] reads_q, writes_q, busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      busy_q   <= '0;
    end else begin
      if (state_q == S_RESP) begin
        if (write_q) begin
          writes_q <= writes_q + 64'd1;
        end else begin
          reads_q <= reads_q + 64'd1;
        end
      end
      if (state_q != S_IDLE) begin
        busy_q <= busy_q + 64'd1;
      end
    end
  end

  assign bridge_reads       = reads_q;
  assign bridge_writes      = writes_q;
  assign bridge_busy_cycles = busy_q;
`endif

endmodule

// File: doc/mem_line_bridge.md
MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width (`M_WIDTH).
REQ-002 SHALL have parameter CL_LEN_BITS, default 128, cache-line width (1 << (`LG_L1D_CL_LEN+3)).
REQ-003 SHALL have parameter BEAT_BITS, default 32, external data beat width; CL_LEN_BITS is an integer multiple of it, so N = CL_LEN_BITS/BEAT_BITS beats (default 4).
REQ-004 SHALL have parameter TAG_WIDTH, default 2, request tag width (`LG_MEM_TAG_ENTRIES).
REQ-005 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- mem_req_valid  in  1  line request; held high until the response cycle.
- mem_req_addr  in  ADDR_WIDTH  line address.
- mem_req_store_data  in  CL_LEN_BITS  line write data.
- mem_req_tag  in  TAG_WIDTH  request tag.
- mem_req_opcode  in  4  4'd4 = line read, 4'd7 = line write.
- mem_rsp_valid  out  1  one-cycle completion pulse.
- mem_rsp_load_data  out  CL_LEN_BITS  assembled read line.
- ext_cmd_valid / ext_cmd_ready  out / in  1 / 1  command handshake.
- ext_cmd_addr  out  ADDR_WIDTH  line-aligned address (low log2(CL_LEN_BITS/8) bits zero).
- ext_cmd_write  out  1  1 = write burst.
- ext_cmd_tag  out  TAG_WIDTH  captured tag.
- ext_wdata_valid / ext_wdata_ready  out / in  1 / 1  write beat handshake.
- ext_wdata  out  BEAT_BITS  write beat.
- ext_wdata_last  out  1  high on beat N-1.
- ext_rdata_valid  in  1  read beat; always accepted, no back-pressure.
- ext_rdata  in  BEAT_BITS  read beat.
- ext_wack_valid  in  1  write burst complete.
- proto_err  out  1  sticky protocol-error flag.

Function
REQ-006 SHALL implement states IDLE, CMD, WDATA, WACK, RDATA, RESP.
REQ-007 In IDLE with mem_req_valid=1, SHALL capture addr, tag, opcode and store data, then enter CMD on the next edge; ext_cmd_valid is registered and rises at t+1.
REQ-008 Any opcode other than 4'd7 SHALL be executed as a line read.
REQ-009 In CMD, SHALL hold ext_cmd_valid and fields stable until ext_cmd_ready=1; on handshake SHALL go to WDATA (write) or RDATA (read) with beat counter = 0.
REQ-010 In WDATA, beat k SHALL carry store_data[k*BEAT_BITS +: BEAT_BITS], starting with k=0; the counter SHALL advance only on valid&&ready; after beat N-1, SHALL go to WACK.
REQ-011 In RDATA, each ext_rdata_valid beat SHALL be written to load_data[k*BEAT_BITS +: BEAT_BITS] and k SHALL increment; after beat N-1, SHALL go to RESP.
REQ-012 In WACK, ext_wack_valid SHALL move the block to RESP.
REQ-013 In RESP, mem_rsp_valid SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE. mem_req_valid SHALL be ignored during RESP.
REQ-014 mem_rsp_load_data SHALL hold the last completed read line until the next read's first beat; write completion SHALL leave it unchanged.
REQ-015 Minimum latency, request to rsp pulse, with ready tied high and beats back-to-back: read = 2+N cycles, write = 3+N cycles (WACK one cycle).
REQ-016 The block SHALL have at most one outstanding request; mem_req_valid is not sampled outside IDLE.
REQ-017 proto_err SHALL set, and stay set until reset, on: ext_rdata_valid outside RDATA; ext_wack_valid outside WACK. The stray event SHALL otherwise be ignored.
REQ-018 Counter wrap: the beat counter is log2(N) bits and SHALL clear to 0 on entering RDATA/WDATA, never relying on wrap.

Reset
REQ-019 reset=0 SHALL asynchronously force: state IDLE, ext_cmd_valid=0, ext_wdata_valid=0, ext_wdata_last=0, mem_rsp_valid=0, mem_rsp_load_data=0, proto_err=0, beat counter=0, and stats counters=0.
REQ-020 Reset mid-burst SHALL abort the burst with no rsp pulse; the first request after release SHALL start cleanly from IDLE.

Configuration
REQ-021 With MEM_LINE_BRIDGE_STATS_EN defined, SHALL add 64-bit outputs bridge_reads, bridge_writes (increment on each RESP cycle by type) and bridge_busy_cycles (increments every cycle state != IDLE). Without it, those ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-022 Read addr 0x1008, all readies=1, beats 0x11,0x22,0x33,0x44 -> ext_cmd_addr=0x1000, one mem_rsp_valid pulse 6 cycles after request, load_data=0x00000044_00000033_00000022_00000011.
REQ-023 Write of line 0xDDDD_CCCC_BBBB_AAAA_... (beat0=0xAAAA...), wdata_ready toggling 1/0 -> beats in order 0..3, last only on beat 3, rsp pulse one cycle after wack.
REQ-024 ext_cmd_ready=0 for 10 cycles -> cmd fields stable, no rsp; then completes normally.
REQ-025 ext_rdata_valid in IDLE -> proto_err=1 and stays 1; load_data unchanged.
REQ-026 reset=0 after beat 2 of a read -> all outputs 0 immediately; new read after release completes with correct data.
REQ-027 With MEM_LINE_BRIDGE_STATS_EN: 2 reads + 1 write -> bridge_reads=2, bridge_writes=1, and bridge_busy_cycles = the sum of the non-IDLE cycles.
